// File: rtl/cutting_cmd_ctrl.sv
`timescale 1ns/1ps
// Purpose : glitch-filtered host command decoder with timed set-point ramp for the cutting ICO.
// Latency : Din change to stop/sweep/target/cmd_err update is STABLE_CNT+3 clocks; ramp steps every RAMP_DIV clocks.
// Backpressure: none; Din is a level sampled every clock. Ramp is built only when CUT_RAMP_EN is defined.
module cutting_cmd_ctrl #(
  parameter int          STABLE_CNT = 40,
  parameter logic [14:0] SP_BASE    = 15'd12460,
  parameter logic [14:0] SP_STEP    = 15'd224,
  parameter logic [14:0] SP_RESET   = 15'd13841,
  parameter int          RAMP_DIV   = 4000,
  parameter logic [14:0] RAMP_STEP  = 15'd1
) (
  input  logic        clk40MHz,
  input  logic        rst_n,
  input  logic [4:0]  Din,
  output logic [14:0] set_point,
  output logic [14:0] target,
  output logic        stop,
  output logic        sweep,
  output logic        ramp_busy,
  output logic        cmd_err
);

  localparam int                CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0]  CNT_ACC = CNT_W'(STABLE_CNT - 1);
  localparam logic [4:0]        CODE_IDLE = 5'd31;

  logic [4:0]       din_m;
  logic [4:0]       din_s;
  logic [4:0]       din_prev;
  logic [4:0]       last_code;
  logic [CNT_W-1:0] stab_cnt;
  logic             accept;
  logic             preset;
  logic [14:0]      code_ext;
  logic [14:0]      sp_calc;

  // Synchronizer, stability counter and last accepted code.
  // Sync flops reset to the idle code so a held 31 after reset is never seen as a change.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      din_m     <= CODE_IDLE;
      din_s     <= CODE_IDLE;
      din_prev  <= CODE_IDLE;
      stab_cnt  <= '0;
      last_code <= CODE_IDLE;
    end else begin
      din_m    <= Din;
      din_s    <= din_m;
      din_prev <= din_s;
      if (din_s != din_prev) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_SAT) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
      if (accept) begin
        last_code <= din_s;
      end
    end
  end

  // Acceptance fires once: the counter passes the threshold only once per stable run,
  // and the last_code check blocks re-sending the same code.
  always_comb begin
    accept   = (din_s == din_prev) && (stab_cnt == CNT_ACC) && (din_s != last_code);
    preset   = accept && (din_s == 5'd25);
    code_ext = {10'd0, din_s};
    if (SP_STEP == 15'd224) begin
      sp_calc = (code_ext << 8) - (code_ext << 5) + SP_BASE;
    end else begin
      sp_calc = code_ext * SP_STEP + SP_BASE;
    end
  end

  // Command decode into target, stop, sweep and the error pulse.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      target  <= SP_RESET;
      stop    <= 1'b1;
      sweep   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept && (din_s >= 5'd26);
      if (accept) begin
        if (din_s <= 5'd20) begin
          target <= sp_calc;
        end else begin
          case (din_s)
            5'd21: stop  <= 1'b0;
            5'd22: stop  <= 1'b1;
            5'd23: sweep <= 1'b1;
            5'd24: sweep <= 1'b0;
            5'd25: begin
              target <= SP_BASE;
              stop   <= 1'b1;
              sweep  <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef CUT_RAMP_EN
  localparam int          DIV_W   = $clog2(RAMP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(RAMP_DIV - 1);
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RAMP = 1'b1;

  logic [0:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [14:0]      sp_dist;
  logic             sp_up;
  logic [14:0]      sp_next;

  // Next set-point one step toward target; snap to target when within one step.
  always_comb begin
    sp_up   = (target >= set_point);
    sp_dist = sp_up ? (target - set_point) : (set_point - target);
    if (sp_dist <= RAMP_STEP) begin
      sp_next = target;
    end else if (sp_up) begin
      sp_next = set_point + RAMP_STEP;
    end else begin
      sp_next = set_point - RAMP_STEP;
    end
  end

  // Ramp FSM and divider; preset overrides everything and aborts the ramp.
  // A retarget mid-ramp leaves the divider running so step spacing is kept.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      set_point <= SP_RESET;
    end else if (preset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      set_point <= SP_BASE;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          if (set_point != target) begin
            state <= ST_RAMP;
          end
        end
        default: begin
          if (set_point == target) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
          end else if (div_cnt == DIV_TC) begin
            div_cnt   <= '0;
            set_point <= sp_next;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign ramp_busy = (state == ST_RAMP);
`else
  localparam int unused_ramp_cfg = RAMP_DIV + int'(RAMP_STEP);

  // Without the ramp, set-point follows target one clock later; preset loads it at once.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      set_point <= SP_RESET;
    end else if (preset) begin
      set_point <= SP_BASE;
    end else begin
      set_point <= target;
    end
  end

  assign ramp_busy = 1'b0;
`endif

endmodule
